// File: rtl/booth_pkg.sv
// rtl/booth_pkg.sv - shared types and constants for the Booth operand sequencer
package booth_pkg;

  localparam int OP_W             = 8;
  localparam int PROD_W           = 16;
  localparam int WDOG_MAX_DEFAULT = 15;

  typedef enum logic [2:0] {
    DRAIN,
    IDLE,
    LAUNCH,
    WAIT_BUSY,
    WAIT_DONE
  } state_t;

endpackage

// File: rtl/booth_op_fifo.sv
// rtl/booth_op_fifo.sv - count-based synchronous FIFO holding {m, r, tag} operand entries
module booth_op_fifo #(
  parameter int WIDTH = 20,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  // Flags come from the registered count only, so a push into a full FIFO is refused even on a pop cycle
  assign full      = (count == FULL_CNT);
  assign empty     = (count == '0);
  assign do_push   = push && !full;
  assign do_pop    = pop && !empty;
  assign head_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/booth_seq.sv
// rtl/booth_seq.sv - operand sequencer and tagged result collector around the 8-bit Booth core
module booth_seq
  import booth_pkg::*;
#(
  parameter int FIFO_DEPTH = 2,
  parameter int TAG_W      = 4,
  parameter int WDOG_MAX   = WDOG_MAX_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   in_m,
  input  logic [OP_W-1:0]   in_r,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PROD_W-1:0] out_product,
  output logic [TAG_W-1:0]  out_tag,
  output logic [OP_W-1:0]   mul_m,
  output logic [OP_W-1:0]   mul_r,
  output logic              mul_start,
  input  logic              mul_busy,
  input  logic [PROD_W-1:0] mul_product,
  output logic              err
);

  localparam int ENT_W = 2*OP_W + TAG_W;
  localparam int WW    = $clog2(WDOG_MAX + 1);
  localparam logic [WW-1:0] WDOG_LIM = WW'(WDOG_MAX);

  state_t            state;
  state_t            state_nx;
  logic [ENT_W-1:0]  head;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_pop;
  logic              push;
  logic [TAG_W-1:0]  cur_tag;
  logic [WW-1:0]     wdog_cnt;
  logic              wdog_tick;
  logic              wdog_trip;
  logic              capture;
  logic              out_free;

  assign in_ready  = !fifo_full && (state != DRAIN);
  assign push      = in_valid && in_ready;
  assign out_free  = !out_valid || out_ready;
  assign mul_start = (state == LAUNCH);

  booth_op_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data ({in_m, in_r, in_tag}),
    .pop       (fifo_pop),
    .head_data (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_comb begin
    state_nx  = state;
    fifo_pop  = 1'b0;
    capture   = 1'b0;
    wdog_tick = 1'b0;
    wdog_trip = 1'b0;
    case (state)
      DRAIN:     if (!mul_busy) state_nx = IDLE;
      IDLE: begin
        if (!fifo_empty && !mul_busy) begin
          fifo_pop = 1'b1;
          state_nx = LAUNCH;
        end
      end
      LAUNCH:    state_nx = WAIT_BUSY;
      WAIT_BUSY: begin
        wdog_tick = 1'b1;
        if (mul_busy) state_nx = WAIT_DONE;
      end
      WAIT_DONE: begin
        // Once busy has fallen the core holds product, so a stall on the output register is not timed
        if (mul_busy) begin
          wdog_tick = 1'b1;
        end else if (out_free) begin
          capture  = 1'b1;
          state_nx = IDLE;
        end
      end
      default:   state_nx = DRAIN;
    endcase
    if (wdog_tick && (wdog_cnt == WDOG_LIM)) begin
      wdog_trip = 1'b1;
      state_nx  = DRAIN;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= DRAIN;
      mul_m       <= '0;
      mul_r       <= '0;
      cur_tag     <= '0;
      wdog_cnt    <= '0;
      err         <= 1'b0;
      out_valid   <= 1'b0;
      out_product <= '0;
      out_tag     <= '0;
    end else begin
      state <= state_nx;
      if (fifo_pop) {mul_m, mul_r, cur_tag} <= head;
      if (state == LAUNCH) begin
        wdog_cnt <= '0;
      end else if (wdog_tick && !wdog_trip) begin
        wdog_cnt <= wdog_cnt + WW'(1);
      end
      if (wdog_trip) err <= 1'b1;
      if (capture) begin
        out_valid   <= 1'b1;
        out_product <= mul_product;
        out_tag     <= cur_tag;
      end else if (out_valid && out_ready) begin
        out_valid   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_booth_seq.sv
// tb/tb_booth_seq.sv - scoreboard bench for booth_seq driving a behavioural Booth core model
`timescale 1ns/1ps
module tb_booth_seq;

  localparam int TAG_W    = 4;
  localparam int WDOG_MAX = 15;

  typedef struct {
    logic [7:0]  m;
    logic [7:0]  r;
    logic [3:0]  tag;
    logic [15:0] prod;
  } vec_t;

  typedef struct {
    logic [15:0] prod;
    logic [3:0]  tag;
  } res_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_m = '0;
  logic [7:0]  in_r = '0;
  logic [3:0]  in_tag = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_product;
  logic [3:0]  out_tag;
  logic [7:0]  mul_m;
  logic [7:0]  mul_r;
  logic        mul_start;
  logic        mul_busy = 1'b0;
  logic [15:0] mul_product = '0;
  logic        err;

  always #5 clk = ~clk;

  booth_seq #(
    .FIFO_DEPTH (2),
    .TAG_W      (TAG_W),
    .WDOG_MAX   (WDOG_MAX)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_m        (in_m),
    .in_r        (in_r),
    .in_tag      (in_tag),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_product (out_product),
    .out_tag     (out_tag),
    .mul_m       (mul_m),
    .mul_r       (mul_r),
    .mul_start   (mul_start),
    .mul_busy    (mul_busy),
    .mul_product (mul_product),
    .err         (err)
  );

  // Core model: no reset, busy for 8 cycles after start, product valid once busy drops
  logic       core_ignore = 1'b0;
  logic [2:0] core_cnt = '0;
  logic [7:0] core_m = '0;
  logic [7:0] core_r = '0;

  function automatic logic [15:0] smul(input logic [7:0] a, input logic [7:0] b);
    logic signed [15:0] sa;
    logic signed [15:0] sb_;
    sa  = $signed({{8{a[7]}}, a});
    sb_ = $signed({{8{b[7]}}, b});
    return 16'(sa * sb_);
  endfunction

  always @(posedge clk) begin
    if (mul_busy) begin
      if (core_cnt == 3'd0) begin
        mul_busy    <= 1'b0;
        mul_product <= smul(core_m, core_r);
      end else begin
        core_cnt <= core_cnt - 3'd1;
      end
    end else if (mul_start && !core_ignore) begin
      core_m   <= mul_m;
      core_r   <= mul_r;
      core_cnt <= 3'd7;
      mul_busy <= 1'b1;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   n_cmp = 0;
  int   n_fail = 0;
  res_t sb[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  int          starts = 0;
  int          start_cyc[$];
  int          valid_rise_cyc = -1;
  logic        prev_valid = 1'b0;
  logic        hold = 1'b0;
  logic [15:0] hold_prod = '0;
  logic [3:0]  hold_tag = '0;

  always @(negedge clk) begin
    res_t e;
    if (rst_n) begin
      if (mul_start) begin
        starts++;
        start_cyc.push_back(cyc);
        check("start_while_busy", 32'(mul_busy), 32'd0);
      end
      if (hold) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_product", 32'(out_product), 32'(hold_prod));
        check("hold_tag", 32'(out_tag), 32'(hold_tag));
      end
      if (out_valid && !prev_valid) valid_rise_cyc = cyc;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_result", 32'(out_valid), 32'd0);
        end else begin
          e = sb.pop_front();
          check("product", 32'(out_product), 32'(e.prod));
          check("tag", 32'(out_tag), 32'(e.tag));
        end
      end
      hold      = out_valid && !out_ready;
      hold_prod = out_product;
      hold_tag  = out_tag;
    end else begin
      hold = 1'b0;
    end
    prev_valid = out_valid;
  end

  // Called just after a rising edge; leaves in_valid high so pushes can run back-to-back
  task automatic push_op(input vec_t v, input bit expect_res, input int budget,
                         output int waited, output int acc_cyc);
    res_t e;
    in_valid = 1'b1;
    in_m     = v.m;
    in_r     = v.r;
    in_tag   = v.tag;
    waited   = 0;
    acc_cyc  = -1;
    @(negedge clk);
    while (!in_ready && waited < budget) begin
      waited++;
      @(negedge clk);
    end
    if (in_ready) begin
      acc_cyc = cyc;
      if (expect_res) begin
        e.prod = v.prod;
        e.tag  = v.tag;
        sb.push_back(e);
      end
      @(posedge clk);
      #1;
    end else begin
      check("push_timeout", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic wait_drain(input int budget, input bit rnd);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(posedge clk);
      #1;
      if (rnd) out_ready = 1'($urandom_range(0, 1));
      n++;
    end
    if (sb.size() != 0) begin
      check("drain_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
    out_ready = 1'b1;
  endtask

  initial begin
    vec_t vecs[8];
    int   w, a, a0, s0, n0, n, bad, l;

    vecs = '{
      '{8'h03, 8'h05, 4'd1, 16'h000F},
      '{8'hFC, 8'h06, 4'd2, 16'hFFE8},
      '{8'h07, 8'hF9, 4'd3, 16'hFFCF},
      '{8'h80, 8'h80, 4'd4, 16'h4000},
      '{8'h7F, 8'h80, 4'd5, 16'hC080},
      '{8'h00, 8'hFF, 4'd6, 16'h0000},
      '{8'hFF, 8'hFF, 4'd7, 16'h0001},
      '{8'h7F, 8'h7F, 4'd8, 16'h3F01}
    };

    // Reset values
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_product", 32'(out_product), 32'd0);
    check("rst_out_tag", 32'(out_tag), 32'd0);
    check("rst_mul_start", 32'(mul_start), 32'd0);
    check("rst_mul_m", 32'(mul_m), 32'd0);
    check("rst_mul_r", 32'(mul_r), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("drain_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;

    // Single op latency
    s0 = starts;
    push_op(vecs[0], 1'b1, 20, w, a);
    in_valid = 1'b0;
    wait_drain(60, 1'b0);
    check("t1_latency", 32'(valid_rise_cyc - a), 32'd12);
    check("t1_starts", 32'(starts - s0), 32'd1);
    check("t1_launch_cyc", 32'(start_cyc[$] - a), 32'd2);

    // Two back-to-back ops
    s0 = starts;
    n0 = start_cyc.size();
    push_op(vecs[1], 1'b1, 20, w, a);
    check("t2_ready_first", 32'(w), 32'd0);
    push_op(vecs[2], 1'b1, 20, w, a);
    check("t2_ready_second", 32'(w), 32'd0);
    in_valid = 1'b0;
    wait_drain(80, 1'b0);
    check("t2_starts", 32'(starts - s0), 32'd2);
    check("t2_start_spacing", 32'(start_cyc[n0+1] - start_cyc[n0]), 32'd11);

    // Whole table streamed, random output backpressure
    for (int i = 0; i < 8; i++) push_op(vecs[i], 1'b1, 40, w, a);
    in_valid = 1'b0;
    wait_drain(400, 1'b1);

    // Full FIFO plus output stall
    out_ready = 1'b0;
    s0 = starts;
    push_op(vecs[3], 1'b1, 20, w, a0);
    push_op(vecs[4], 1'b1, 20, w, a);
    check("t3_second_push", 32'(w), 32'd0);
    push_op(vecs[5], 1'b1, 20, w, a);
    check("t3_third_push", 32'(w), 32'd0);
    push_op(vecs[6], 1'b1, 40, w, a);
    check("t3_fourth_stall", 32'(a - a0), 32'd13);
    in_valid = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    check("t3_held_valid", 32'(out_valid), 32'd1);
    check("t3_no_extra_start", 32'(starts - s0), 32'd2);
    out_ready = 1'b1;
    wait_drain(150, 1'b0);
    check("t3_total_starts", 32'(starts - s0), 32'd4);

    // Reset in the middle of an op
    push_op(vecs[7], 1'b0, 20, w, a);
    in_valid = 1'b0;
    n = 0;
    while (!mul_busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("t4_busy_seen", 32'(mul_busy), 32'd1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bad = 0;
    n = 0;
    while (n < 20) begin
      @(negedge clk);
      if (!mul_busy) break;
      if (in_ready || out_valid) bad++;
      n++;
    end
    check("t4_ready_low_while_busy", 32'(bad), 32'd0);
    @(posedge clk);
    #1;
    s0 = starts;
    push_op(vecs[0], 1'b1, 5, w, a);
    in_valid = 1'b0;
    wait_drain(60, 1'b0);
    check("t4_recover_starts", 32'(starts - s0), 32'd1);
    check("t4_err", 32'(err), 32'd0);

    // Watchdog: core ignores start
    core_ignore = 1'b1;
    n0 = start_cyc.size();
    push_op(vecs[1], 1'b0, 20, w, a);
    in_valid = 1'b0;
    n = 0;
    while (start_cyc.size() == n0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("t5_launch", 32'(start_cyc.size()), 32'(n0 + 1));
    l = start_cyc[n0];
    while (cyc < l + WDOG_MAX) @(negedge clk);
    check("t5_err_not_yet", 32'(err), 32'd0);
    while (cyc < l + WDOG_MAX + 2) @(negedge clk);
    check("t5_err_set", 32'(err), 32'd1);
    repeat (5) @(negedge clk);
    check("t5_no_result", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    core_ignore = 1'b0;
    push_op(vecs[2], 1'b1, 20, w, a);
    in_valid = 1'b0;
    wait_drain(60, 1'b0);
    check("t5_err_sticky", 32'(err), 32'd1);

    repeat (3) @(negedge clk);
    check("end_out_valid", 32'(out_valid), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/booth_seq.md
# booth_seq

Operand sequencer and result collector wrapped around the 8-bit Booth multiplier core. It accepts signed operand pairs on a valid/ready stream and buffers them in a small FIFO. It launches one multiplication at a time using the core's `start`/`busy` protocol, captures the 16-bit product when `busy` falls, and presents tagged results on a valid/ready output stream. It sits between the operand source and the multiplier core, and between the core and the result consumer.

## Interface
- `FIFO_DEPTH`, 2: operand FIFO entries, power of two, ≥2.
- `TAG_W`, 4: width of the user tag carried with each operation.
- `WDOG_MAX`, 15: maximum cycles allowed in WAIT_BUSY + WAIT_DONE before an error is declared.
- `clk` in 1: single clock, all logic on rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `in_valid` in 1: operand pair offered.
- `in_ready` out 1: high when FIFO not full and state ≠ DRAIN.
- `in_m` in 8: multiplicand.
- `in_r` in 8: multiplier.
- `in_tag` in TAG_W: tag returned with the result.
- `out_valid` out 1: result held in output register.
- `out_ready` in 1: consumer accepts result.
- `out_product` out 16: captured product.
- `out_tag` out TAG_W: tag of that product.
- `mul_m` out 8: to core `m`.
- `mul_r` out 8: to core `r`.
- `mul_start` out 1: to core `start`, one-cycle pulse.
- `mul_busy` in 1: from core `busy`.
- `mul_product` in 16: from core `product`.
- `err` out 1: sticky watchdog error; cleared only by reset.

## Operation
- Reset values: `in_ready`=0, `out_valid`=0, `out_product`=0, `out_tag`=0, `mul_start`=0, `mul_m`=`mul_r`=0, `err`=0. The FIFO is emptied and the state is DRAIN.
- In-handshake: an op is pushed when `in_valid && in_ready`.
- Out-handshake: the result is popped when `out_valid && out_ready`. Payload stays stable while `out_valid && !out_ready`.
- `mul_m`/`mul_r` are registered from the FIFO head at launch and held until the next launch.
- States:
  - DRAIN: the core has no reset and may still be running. Go to IDLE on the first cycle with `mul_busy`=0.
  - IDLE: if the FIFO is non-empty and `mul_busy`=0, pop the head, load `mul_m`/`mul_r`/tag, and go to LAUNCH.
  - LAUNCH: `mul_start`=1 for exactly this cycle. Go to WAIT_BUSY.
  - WAIT_BUSY: go to WAIT_DONE when `mul_busy`=1.
  - WAIT_DONE: when `mul_busy`=0 and the output register is free (`!out_valid`, or popped this cycle), load `out_product`←`mul_product` and `out_tag`←held tag, set `out_valid`, and go to IDLE. If `mul_busy`=0 but the output register is occupied, stay in WAIT_DONE. The core holds `product`, so no data is lost.
- Watchdog:
  - Counts cycles spent in WAIT_BUSY/WAIT_DONE while `mul_busy` has not yet completed a rise-and-fall. It does not count cycles stalled on a full output register.
  - Exceeding `WDOG_MAX` sets `err`, drops the op (no result is produced), and enters DRAIN.
- Products pass through unmodified: no sign extension, truncation, or correction.
- Ordering is strictly FIFO. Tags are not interpreted.
- Simultaneous push and pop on the FIFO are allowed in the same cycle, including when it is full: `in_ready` depends only on the registered count, so a push into a full FIFO is never accepted even if a pop occurs.
- Reset asserted mid-operation: all state clears as above. The in-flight op is lost. The block waits in DRAIN for the core to finish before launching again.

## Timing
- Core contract: `busy` rises the cycle after `start` is sampled, stays high 8 cycles, and `product` is valid from the first cycle `busy` is low.
- Latency with an empty pipe (accept in cycle 0):
  - cycle 1: IDLE pop.
  - cycle 2: LAUNCH.
  - cycles 3–10: busy.
  - cycle 11: capture.
  - cycle 12: `out_valid`=1.
  - Total: 12 cycles.
- Throughput: one op per 11 cycles, since the next LAUNCH follows the capture by 2 cycles.
- `mul_start` is never asserted while `mul_busy`=1 or in DRAIN.
- `in_ready` is low in DRAIN and during reset.

## Structure
- Package `booth_pkg`:
  - state enum {DRAIN, IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE}.
  - constants `OP_W`=8 and `PROD_W`=16.
  - default `WDOG_MAX`.
- Sub-module `booth_op_fifo`: synchronous FIFO with parameters width `2*OP_W+TAG_W` and depth `FIFO_DEPTH`. It provides count-based full/empty flags and registered read data at the head.

## Test plan
- Single op, `m`=3, `r`=5, tag=1, `out_ready`=1 held, behavioural core model → `out_valid` in cycle 12 with `out_product`=0x000F, `out_tag`=1. `mul_start` pulses exactly once.
- Two ops pushed back-to-back, (−4,6) tag 2 then (7,−7) tag 3 → `in_ready` stays high for both (FIFO depth 2). Results arrive in order: 0xFFE8/2, then 0xFFCF/3. The second `mul_start` comes 11 cycles after the first.
- Full FIFO plus output stall: `out_ready`=0, push 4 ops → the third push is accepted once the first launches and the fourth stalls. Hold `out_ready`=0 for 30 cycles → WAIT_DONE holds, with no second `mul_start`. Release → all results drain in order.
- Reset mid-op: assert `rst_n`=0 for 1 cycle while `mul_busy`=1 → `in_ready`=0 until the model's `busy` falls, no result for the lost op, and the next op completes normally.
- Watchdog: the core model ignores `start` → `err`=1 after `WDOG_MAX` cycles. The op is dropped, `out_valid` stays 0, and later ops still complete when the model recovers.
